// File: rtl/sdram_pro_mport_arb.sv
// Multi-channel round-robin burst scheduler in front of a single-port SDRAM controller.
// Grants one write or read burst at a time and keeps per-channel wrapping address pointers.
module sdram_pro_mport_arb #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned ADDR_W        = 23,
  parameter int unsigned LEN_W         = 8,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned RD_FIFO_DEPTH = 512
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     init_end,
  input  logic [NUM_CH-1:0]        ch_wr_en,
  input  logic [NUM_CH-1:0]        ch_rd_en,
  input  logic [NUM_CH*ADDR_W-1:0] ch_wr_b_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_wr_e_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_rd_b_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_rd_e_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_wr_burst_len,
  input  logic [NUM_CH*LEN_W-1:0]  ch_rd_burst_len,
  input  logic [NUM_CH*CNT_W-1:0]  ch_wr_fifo_num,
  input  logic [NUM_CH*CNT_W-1:0]  ch_rd_fifo_num,
  input  logic [NUM_CH-1:0]        ch_addr_rst,
  output logic                     sdram_wr_req,
  output logic [ADDR_W-1:0]        sdram_wr_addr,
  output logic [LEN_W-1:0]         sdram_wr_len,
  input  logic                     sdram_wr_ack,
  input  logic                     sdram_wr_end,
  output logic                     sdram_rd_req,
  output logic [ADDR_W-1:0]        sdram_rd_addr,
  output logic [LEN_W-1:0]         sdram_rd_len,
  input  logic                     sdram_rd_ack,
  input  logic                     sdram_rd_end,
  output logic [NUM_CH-1:0]        gnt_onehot,
  output logic                     gnt_is_wr,
  output logic                     busy
);

  localparam int unsigned NumSlots = 2 * NUM_CH;
  localparam int unsigned SlotW    = $clog2(NumSlots);
  localparam int unsigned ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CmpW     = (CNT_W + 1 > LEN_W) ? CNT_W + 1 : LEN_W;
  localparam logic [CNT_W:0]  RdDepth = (CNT_W + 1)'(RD_FIFO_DEPTH);
  localparam logic [ADDR_W:0] AddrOne = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrWait, StRdReq, StRdWait} state_e;

  state_e             state_q;
  logic [SlotW-1:0]   rr_q;
  logic [ChW-1:0]     gnt_ch_q;
  logic [ADDR_W-1:0]  cur_q, b_q, e_q;
  logic [LEN_W-1:0]   len_q;
  logic               rst_pend_q;
  logic [NUM_CH-1:0]  wr_loaded_q, rd_loaded_q, wr_loaded_d, rd_loaded_d;
  logic [ADDR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [ADDR_W-1:0]  rd_ptr_q [NUM_CH];

  logic [ADDR_W-1:0]  wr_b [NUM_CH];
  logic [ADDR_W-1:0]  wr_e [NUM_CH];
  logic [ADDR_W-1:0]  rd_b [NUM_CH];
  logic [ADDR_W-1:0]  rd_e [NUM_CH];
  logic [ADDR_W-1:0]  wr_eff [NUM_CH];
  logic [ADDR_W-1:0]  rd_eff [NUM_CH];
  logic [LEN_W-1:0]   wr_len [NUM_CH];
  logic [LEN_W-1:0]   rd_len [NUM_CH];
  logic [NumSlots-1:0] slot_elig;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W:0] rd_used;
    logic [CNT_W:0] rd_space;

    assign wr_b[k]   = ch_wr_b_addr[k*ADDR_W +: ADDR_W];
    assign wr_e[k]   = ch_wr_e_addr[k*ADDR_W +: ADDR_W];
    assign rd_b[k]   = ch_rd_b_addr[k*ADDR_W +: ADDR_W];
    assign rd_e[k]   = ch_rd_e_addr[k*ADDR_W +: ADDR_W];
    assign wr_len[k] = ch_wr_burst_len[k*LEN_W +: LEN_W];
    assign rd_len[k] = ch_rd_burst_len[k*LEN_W +: LEN_W];

    // Free space in the read FIFO, saturating at zero if the fill level is out of range.
    assign rd_used  = {1'b0, ch_rd_fifo_num[k*CNT_W +: CNT_W]};
    assign rd_space = (rd_used > RdDepth) ? '0 : RdDepth - rd_used;

    assign slot_elig[2*k] = init_end & ch_wr_en[k] & (wr_len[k] != '0) &
                            (CmpW'(ch_wr_fifo_num[k*CNT_W +: CNT_W]) >= CmpW'(wr_len[k]));
    assign slot_elig[2*k+1] = init_end & ch_rd_en[k] & (rd_len[k] != '0) &
                              (CmpW'(rd_space) >= CmpW'(rd_len[k]));

    // A reload pulse in the grant cycle itself already forces the begin address.
    assign wr_eff[k] = (wr_loaded_q[k] & ~ch_addr_rst[k]) ? wr_ptr_q[k] : wr_b[k];
    assign rd_eff[k] = (rd_loaded_q[k] & ~ch_addr_rst[k]) ? rd_ptr_q[k] : rd_b[k];
  end

  logic              grant_found;
  logic [SlotW-1:0]  sel, idx, rr_nxt;
  int unsigned       idx_sum;

  always_comb begin
    grant_found = 1'b0;
    sel         = '0;
    idx         = '0;
    idx_sum     = 0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      idx_sum = 32'(rr_q) + i;
      if (idx_sum >= NumSlots) idx_sum = idx_sum - NumSlots;
      idx = SlotW'(idx_sum);
      if (!grant_found && slot_elig[idx]) begin
        grant_found = 1'b1;
        sel         = idx;
      end
    end
  end

  logic              sel_wr;
  logic [ChW-1:0]    sel_ch;
  logic [ADDR_W-1:0] sel_addr, sel_b, sel_e;
  logic [LEN_W-1:0]  sel_len;

  assign sel_wr   = ~sel[0];
  assign sel_ch   = ChW'(sel >> 1);
  assign sel_addr = sel_wr ? wr_eff[sel_ch] : rd_eff[sel_ch];
  assign sel_b    = sel_wr ? wr_b[sel_ch]   : rd_b[sel_ch];
  assign sel_e    = sel_wr ? wr_e[sel_ch]   : rd_e[sel_ch];
  assign sel_len  = sel_wr ? wr_len[sel_ch] : rd_len[sel_ch];
  assign rr_nxt   = (sel == SlotW'(NumSlots - 1)) ? '0 : sel + SlotW'(1);

  // Next pointer; falls back to the begin address if the following burst would overrun.
  logic [ADDR_W:0]   nxt_sum, nxt_last, b_last, e_ext;
  logic [ADDR_W-1:0] upd_ptr;

  always_comb begin
    e_ext    = {1'b0, e_q};
    nxt_sum  = {1'b0, cur_q} + (ADDR_W + 1)'(len_q);
    nxt_last = nxt_sum + (ADDR_W + 1)'(len_q) - AddrOne;
    b_last   = {1'b0, b_q} + (ADDR_W + 1)'(len_q) - AddrOne;
    upd_ptr  = ((b_last > e_ext) || (nxt_last > e_ext)) ? b_q : nxt_sum[ADDR_W-1:0];
  end

  logic burst_done, rst_hit, gnt_rst_now;
  logic [NUM_CH-1:0] clr_now;

  assign busy        = (state_q != StIdle);
  assign gnt_rst_now = busy & |(ch_addr_rst & gnt_onehot);
  assign rst_hit     = rst_pend_q | gnt_rst_now;
  assign clr_now     = busy ? (ch_addr_rst & ~gnt_onehot) : ch_addr_rst;
  assign burst_done  = ((state_q == StWrReq)  & sdram_wr_ack & sdram_wr_end) |
                       ((state_q == StWrWait) & sdram_wr_end) |
                       ((state_q == StRdReq)  & sdram_rd_ack & sdram_rd_end) |
                       ((state_q == StRdWait) & sdram_rd_end);

  always_comb begin
    wr_loaded_d = wr_loaded_q & ~clr_now;
    rd_loaded_d = rd_loaded_q & ~clr_now;
    if (burst_done) begin
      if (rst_hit) begin
        wr_loaded_d = wr_loaded_d & ~gnt_onehot;
        rd_loaded_d = rd_loaded_d & ~gnt_onehot;
      end else if (gnt_is_wr) begin
        wr_loaded_d = wr_loaded_d | gnt_onehot;
      end else begin
        rd_loaded_d = rd_loaded_d | gnt_onehot;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      rr_q          <= '0;
      gnt_ch_q      <= '0;
      gnt_onehot    <= '0;
      gnt_is_wr     <= 1'b0;
      cur_q         <= '0;
      b_q           <= '0;
      e_q           <= '0;
      len_q         <= '0;
      rst_pend_q    <= 1'b0;
      wr_loaded_q   <= '0;
      rd_loaded_q   <= '0;
      wr_ptr_q      <= '{default: '0};
      rd_ptr_q      <= '{default: '0};
      sdram_wr_req  <= 1'b0;
      sdram_wr_addr <= '0;
      sdram_wr_len  <= '0;
      sdram_rd_req  <= 1'b0;
      sdram_rd_addr <= '0;
      sdram_rd_len  <= '0;
    end else begin
      wr_loaded_q <= wr_loaded_d;
      rd_loaded_q <= rd_loaded_d;

      if (burst_done) begin
        if (!rst_hit) begin
          if (gnt_is_wr) wr_ptr_q[gnt_ch_q] <= upd_ptr;
          else           rd_ptr_q[gnt_ch_q] <= upd_ptr;
        end
        rst_pend_q <= 1'b0;
      end else if (gnt_rst_now) begin
        rst_pend_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            state_q    <= sel_wr ? StWrReq : StRdReq;
            rr_q       <= rr_nxt;
            gnt_ch_q   <= sel_ch;
            gnt_onehot <= NUM_CH'(1) << sel_ch;
            gnt_is_wr  <= sel_wr;
            cur_q      <= sel_addr;
            b_q        <= sel_b;
            e_q        <= sel_e;
            len_q      <= sel_len;
            if (sel_wr) begin
              sdram_wr_req  <= 1'b1;
              sdram_wr_addr <= sel_addr;
              sdram_wr_len  <= sel_len;
            end else begin
              sdram_rd_req  <= 1'b1;
              sdram_rd_addr <= sel_addr;
              sdram_rd_len  <= sel_len;
            end
          end
        end
        StWrReq: begin
          if (sdram_wr_ack) begin
            sdram_wr_req <= 1'b0;
            if (sdram_wr_end) begin
              state_q    <= StIdle;
              gnt_onehot <= '0;
              gnt_is_wr  <= 1'b0;
            end else begin
              state_q <= StWrWait;
            end
          end
        end
        StWrWait: begin
          if (sdram_wr_end) begin
            state_q    <= StIdle;
            gnt_onehot <= '0;
            gnt_is_wr  <= 1'b0;
          end
        end
        StRdReq: begin
          if (sdram_rd_ack) begin
            sdram_rd_req <= 1'b0;
            if (sdram_rd_end) begin
              state_q    <= StIdle;
              gnt_onehot <= '0;
              gnt_is_wr  <= 1'b0;
            end else begin
              state_q <= StRdWait;
            end
          end
        end
        StRdWait: begin
          if (sdram_rd_end) begin
            state_q    <= StIdle;
            gnt_onehot <= '0;
            gnt_is_wr  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pro_mport_arb.sv
// Directed bench for sdram_pro_mport_arb with two channels and a hand-driven controller.
module tb_sdram_pro_mport_arb;

  logic        clk, rst, init_end;
  logic [1:0]  ch_wr_en, ch_rd_en, ch_addr_rst;
  logic [45:0] wr_b, wr_e, rd_b, rd_e;
  logic [15:0] wr_len, rd_len;
  logic [19:0] wr_num, rd_num;
  logic        wr_req, wr_ack, wr_end, rd_req, rd_ack, rd_end, gnt_is_wr, busy;
  logic [22:0] wr_addr, rd_addr;
  logic [7:0]  wr_l, rd_l;
  logic [1:0]  gnt_onehot;

  int checks = 0;
  int errors = 0;

  sdram_pro_mport_arb dut (
    .sys_clk(clk), .sys_rst(rst), .init_end(init_end),
    .ch_wr_en(ch_wr_en), .ch_rd_en(ch_rd_en),
    .ch_wr_b_addr(wr_b), .ch_wr_e_addr(wr_e), .ch_rd_b_addr(rd_b), .ch_rd_e_addr(rd_e),
    .ch_wr_burst_len(wr_len), .ch_rd_burst_len(rd_len),
    .ch_wr_fifo_num(wr_num), .ch_rd_fifo_num(rd_num), .ch_addr_rst(ch_addr_rst),
    .sdram_wr_req(wr_req), .sdram_wr_addr(wr_addr), .sdram_wr_len(wr_l),
    .sdram_wr_ack(wr_ack), .sdram_wr_end(wr_end),
    .sdram_rd_req(rd_req), .sdram_rd_addr(rd_addr), .sdram_rd_len(rd_l),
    .sdram_rd_ack(rd_ack), .sdram_rd_end(rd_end),
    .gnt_onehot(gnt_onehot), .gnt_is_wr(gnt_is_wr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input int ch, input logic [22:0] b, input logic [22:0] e,
                        input logic [7:0] len, input logic [9:0] num);
    wr_b[ch*23 +: 23] = b;
    wr_e[ch*23 +: 23] = e;
    wr_len[ch*8 +: 8] = len;
    wr_num[ch*10 +: 10] = num;
  endtask

  task automatic set_rd(input int ch, input logic [22:0] b, input logic [22:0] e,
                        input logic [7:0] len, input logic [9:0] num);
    rd_b[ch*23 +: 23] = b;
    rd_e[ch*23 +: 23] = e;
    rd_len[ch*8 +: 8] = len;
    rd_num[ch*10 +: 10] = num;
  endtask

  task automatic pulse_addr_rst(input logic [1:0] m);
    ch_addr_rst = m;
    @(negedge clk);
    ch_addr_rst = 2'b00;
  endtask

  // Waits (bounded) for a request, checks grant/address/length, then acks and ends the burst.
  // Returns at the negedge of the dead IDLE cycle that follows the end.
  task automatic burst(input string tag, input logic exp_wr, input logic [1:0] exp_gnt,
                       input logic [22:0] exp_addr, input logic [7:0] exp_len);
    int n = 0;
    while (!(wr_req || rd_req) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req"}, 32'(wr_req | rd_req), 1);
    chk({tag, " dir"}, 32'(gnt_is_wr), 32'(exp_wr));
    chk({tag, " gnt"}, 32'(gnt_onehot), 32'(exp_gnt));
    chk({tag, " addr"}, 32'(exp_wr ? wr_addr : rd_addr), 32'(exp_addr));
    chk({tag, " len"}, 32'(exp_wr ? wr_l : rd_l), 32'(exp_len));
    if (exp_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    chk({tag, " req drop"}, 32'(wr_req | rd_req), 0);
    if (exp_wr) wr_end = 1'b1; else rd_end = 1'b1;
    @(negedge clk);
    wr_end = 1'b0;
    rd_end = 1'b0;
    chk({tag, " idle"}, 32'({busy, gnt_onehot, gnt_is_wr}), 0);
  endtask

  initial begin
    int seen;
    // Reset with every input active
    rst = 1'b1; init_end = 1'b1; ch_wr_en = 2'b11; ch_rd_en = 2'b11; ch_addr_rst = 2'b11;
    wr_ack = 1'b1; wr_end = 1'b1; rd_ack = 1'b1; rd_end = 1'b1;
    wr_b = '0; wr_e = '1; rd_b = '0; rd_e = '1; wr_len = '1; rd_len = '1;
    wr_num = '1; rd_num = '0;
    repeat (3) @(negedge clk);
    chk("rst outputs", 32'({wr_req, rd_req, gnt_is_wr, busy, gnt_onehot}), 0);
    chk("rst addrs", 32'(wr_addr | rd_addr), 0);
    chk("rst lens", 32'({wr_l, rd_l}), 0);

    init_end = 1'b0; ch_addr_rst = 2'b00;
    wr_ack = 1'b0; wr_end = 1'b0; rd_ack = 1'b0; rd_end = 1'b0;
    ch_wr_en = 2'b01; ch_rd_en = 2'b00;
    set_wr(0, 23'h100, 23'h1FF, 8'd8, 10'd8);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_req || rd_req || busy) seen++;
    end
    chk("no grant without init_end", 32'(seen), 0);

    // Single write stream
    init_end = 1'b1;
    @(negedge clk);
    chk("t2 req", 32'({wr_req, rd_req}), 32'h2);
    chk("t2 addr", 32'(wr_addr), 32'h100);
    chk("t2 len", 32'(wr_l), 8);
    chk("t2 gnt", 32'({gnt_onehot, gnt_is_wr, busy}), 32'b0111);
    rd_ack = 1'b1; rd_end = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0; rd_end = 1'b0;
    chk("t2 wrong dir ignored", 32'({wr_req, rd_req, busy}), 32'b101);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    chk("t2 ack drops req", 32'({wr_req, busy}), 32'b01);
    @(negedge clk);
    chk("t2 wait holds", 32'({wr_req, busy, gnt_onehot}), 32'b0101);
    wr_end = 1'b1;
    @(negedge clk);
    wr_end = 1'b0;
    chk("t2 end idle", 32'({wr_req, busy, gnt_onehot, gnt_is_wr}), 0);
    @(negedge clk);
    chk("t2 second req", 32'(wr_req), 1);
    burst("t2 b2", 1'b1, 2'b01, 23'h108, 8'd8);
    ch_wr_en = 2'b00;

    // Wrap inside a two-burst window, then a window under two bursts
    set_wr(0, 23'h0, 23'd15, 8'd8, 10'd8);
    pulse_addr_rst(2'b01);
    ch_wr_en = 2'b01;
    burst("t3 a0", 1'b1, 2'b01, 23'd0, 8'd8);
    burst("t3 a1", 1'b1, 2'b01, 23'd8, 8'd8);
    burst("t3 a2", 1'b1, 2'b01, 23'd0, 8'd8);
    burst("t3 a3", 1'b1, 2'b01, 23'd8, 8'd8);
    ch_wr_en = 2'b00;
    set_wr(0, 23'h0, 23'd11, 8'd8, 10'd8);
    pulse_addr_rst(2'b01);
    ch_wr_en = 2'b01;
    burst("t3 b0", 1'b1, 2'b01, 23'd0, 8'd8);
    burst("t3 b1", 1'b1, 2'b01, 23'd0, 8'd8);
    burst("t3 b2", 1'b1, 2'b01, 23'd0, 8'd8);

    // Round-robin from a fresh reset
    rst = 1'b1;
    set_wr(0, 23'h100, 23'h1FF, 8'd8, 10'd8);
    set_wr(1, 23'h200, 23'h2FF, 8'd4, 10'd16);
    set_rd(1, 23'h400, 23'h4FF, 8'd8, 10'd0);
    ch_wr_en = 2'b11; ch_rd_en = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    burst("t4 ch0W", 1'b1, 2'b01, 23'h100, 8'd8);
    burst("t4 ch1W", 1'b1, 2'b10, 23'h200, 8'd4);
    burst("t4 ch1R", 1'b0, 2'b10, 23'h400, 8'd8);
    burst("t4 ch0W 2", 1'b1, 2'b01, 23'h108, 8'd8);
    burst("t4 ch1W 2", 1'b1, 2'b10, 23'h204, 8'd4);
    burst("t4 ch1R 2", 1'b0, 2'b10, 23'h408, 8'd8);
    ch_wr_en = 2'b00; ch_rd_en = 2'b00;

    // Read flow control on free FIFO space
    set_rd(0, 23'h800, 23'h8FF, 8'd8, 10'd508);
    ch_rd_en = 2'b01;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rd_req || busy) seen++;
    end
    chk("t5 no room", 32'(seen), 0);
    set_rd(0, 23'h800, 23'h8FF, 8'd8, 10'd504);
    @(negedge clk);
    chk("t5 rd_req", 32'({wr_req, rd_req, gnt_is_wr}), 32'b010);
    chk("t5 rd addr", 32'(rd_addr), 32'h800);
    rd_ack = 1'b1; rd_end = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0; rd_end = 1'b0;
    chk("t5 ack+end idle", 32'({rd_req, busy}), 0);
    burst("t5 b2", 1'b0, 2'b01, 23'h808, 8'd8);
    ch_rd_en = 2'b00;

    // Pointer reload while the channel is mid-burst
    pulse_addr_rst(2'b01);
    set_wr(0, 23'h100, 23'h1FF, 8'd8, 10'd8);
    ch_wr_en = 2'b01;
    burst("t6 b1", 1'b1, 2'b01, 23'h100, 8'd8);
    @(negedge clk);
    chk("t6 b2 addr", 32'({wr_req, wr_addr}), 32'h800108);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    pulse_addr_rst(2'b01);
    chk("t6 still busy", 32'(busy), 1);
    wr_end = 1'b1;
    @(negedge clk);
    wr_end = 1'b0;
    burst("t6 b3", 1'b1, 2'b01, 23'h100, 8'd8);
    ch_wr_en = 2'b00;

    // Asynchronous reset in RD_WAIT
    ch_rd_en = 2'b01;
    @(negedge clk);
    chk("t6 rd req", 32'({rd_req, rd_addr}), 32'h800800);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("t6 rd wait", 32'({rd_req, busy}), 32'b01);
    #2 rst = 1'b1;
    #1;
    chk("t6 async rst ctl", 32'({wr_req, rd_req, busy, gnt_onehot, gnt_is_wr}), 0);
    chk("t6 async rst data", 32'(wr_addr | rd_addr | 23'({wr_l, rd_l})), 0);
    @(negedge clk);
    rst = 1'b0;
    ch_rd_en = 2'b00;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
